// File: rtl/uart_rx_cfg_ctrl.sv
// uart_rx_cfg_ctrl
// Runtime configuration controller for the UART receive path. Holds the live
// PRESCALE/PAR_EN/PAR_TYP settings and only changes them at a frame boundary:
// the receiver is drained, gated off, reconfigured, and re-enabled once the
// line has been seen idle for SETTLE_CYC consecutive cycles. Also keeps
// saturating good-frame / dropped-frame counters for status readback.
//
// Optional feature macro: UART_RX_CFG_CNT_CLR_ON_APPLY_EN
//   defined   -> both counters are cleared in the APPLY cycle (clear wins over
//                a coincident strobe), so status reflects only the new config.
//   undefined -> counters clear only on reset or cnt_clr_i.
module uart_rx_cfg_ctrl #(
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned PRESCALE_RST = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [5:0]       cfg_prescale_i,
    input  logic             cfg_par_en_i,
    input  logic             cfg_par_typ_i,
    output logic             cfg_err_o,
    input  logic             rx_in_i,
    input  logic             rx_busy_i,
    input  logic             data_valid_i,
    input  logic             err_stb_i,
    input  logic             cnt_clr_i,
    output logic [5:0]       prescale_o,
    output logic             par_en_o,
    output logic             par_typ_o,
    output logic             rx_en_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_APPLY  = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam logic [7:0]       SETTLE_TGT  = 8'(SETTLE_CYC);
    localparam logic [5:0]       PRESC_RST_V = 6'(PRESCALE_RST);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic             rx_en_q, rx_en_d;
    logic             cfg_err_q, cfg_err_d;
    logic [5:0]       prescale_q, prescale_d;
    logic             par_en_q, par_en_d;
    logic             par_typ_q, par_typ_d;
    logic [5:0]       sh_prescale_q, sh_prescale_d;
    logic             sh_par_en_q, sh_par_en_d;
    logic             sh_par_typ_q, sh_par_typ_d;
    logic [7:0]       settle_q, settle_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic presc_legal;
    logic accept;

    assign presc_legal = (cfg_prescale_i == 6'd8) || (cfg_prescale_i == 6'd16) ||
                         (cfg_prescale_i == 6'd32);
    assign accept      = cfg_valid_i && ready_q;

    // Config sequencer: RUN -> DRAIN -> APPLY -> SETTLE -> RUN
    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        rx_en_d       = rx_en_q;
        cfg_err_d     = 1'b0;
        prescale_d    = prescale_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        sh_prescale_d = sh_prescale_q;
        sh_par_en_d   = sh_par_en_q;
        sh_par_typ_d  = sh_par_typ_q;
        settle_d      = settle_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (presc_legal) begin
                        sh_prescale_d = cfg_prescale_i;
                        sh_par_en_d   = cfg_par_en_i;
                        sh_par_typ_d  = cfg_par_typ_i;
                        ready_d       = 1'b0;
                        state_d       = ST_DRAIN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Let the in-flight frame finish before gating the receiver.
                if (!rx_busy_i) begin
                    rx_en_d = 1'b0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                prescale_d = sh_prescale_q;
                par_en_d   = sh_par_en_q;
                par_typ_d  = sh_par_typ_q;
                settle_d   = 8'd0;
                state_d    = ST_SETTLE;
            end
            default: begin
                // Count is checked registered, so re-enable lands one cycle
                // after the idle run reaches SETTLE_CYC.
                if (settle_q == SETTLE_TGT) begin
                    rx_en_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_RUN;
                end else if (rx_in_i) begin
                    settle_d = settle_q + 8'd1;
                end else begin
                    settle_d = 8'd0;
                end
            end
        endcase
    end

    // Saturating status counters; clear has priority over increments
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (data_valid_i && (frame_cnt_q != CNT_MAX)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (err_stb_i && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
`ifdef UART_RX_CFG_CNT_CLR_ON_APPLY_EN
        if (state_q == ST_APPLY) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end
`endif
        if (cnt_clr_i) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end
    end

    // State and output registers; reset aborts any pending config
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_RUN;
            ready_q       <= 1'b1;
            rx_en_q       <= 1'b1;
            cfg_err_q     <= 1'b0;
            prescale_q    <= PRESC_RST_V;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            sh_prescale_q <= PRESC_RST_V;
            sh_par_en_q   <= 1'b0;
            sh_par_typ_q  <= 1'b0;
            settle_q      <= 8'd0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            rx_en_q       <= rx_en_d;
            cfg_err_q     <= cfg_err_d;
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            sh_prescale_q <= sh_prescale_d;
            sh_par_en_q   <= sh_par_en_d;
            sh_par_typ_q  <= sh_par_typ_d;
            settle_q      <= settle_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = cfg_err_q;
    assign prescale_o  = prescale_q;
    assign par_en_o    = par_en_q;
    assign par_typ_o   = par_typ_q;
    assign rx_en_o     = rx_en_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_cfg_ctrl.sv
// Directed testbench for uart_rx_cfg_ctrl (SETTLE_CYC=16, PRESCALE_RST=8, CNT_W=8).
module tb_uart_rx_cfg_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [5:0] cfg_prescale_i;
    logic       cfg_par_en_i;
    logic       cfg_par_typ_i;
    logic       cfg_err_o;
    logic       rx_in_i;
    logic       rx_busy_i;
    logic       data_valid_i;
    logic       err_stb_i;
    logic       cnt_clr_i;
    logic [5:0] prescale_o;
    logic       par_en_o;
    logic       par_typ_o;
    logic       rx_en_o;
    logic [7:0] frame_cnt_o;
    logic [7:0] err_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    uart_rx_cfg_ctrl #(
        .SETTLE_CYC  (16),
        .PRESCALE_RST(8),
        .CNT_W       (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_prescale_i(cfg_prescale_i),
        .cfg_par_en_i  (cfg_par_en_i),
        .cfg_par_typ_i (cfg_par_typ_i),
        .cfg_err_o     (cfg_err_o),
        .rx_in_i       (rx_in_i),
        .rx_busy_i     (rx_busy_i),
        .data_valid_i  (data_valid_i),
        .err_stb_i     (err_stb_i),
        .cnt_clr_i     (cnt_clr_i),
        .prescale_o    (prescale_o),
        .par_en_o      (par_en_o),
        .par_typ_o     (par_typ_o),
        .rx_en_o       (rx_en_o),
        .frame_cnt_o   (frame_cnt_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock; inputs driven and outputs sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Ticks until rx_en_o rises, bounded at 100 cycles
    task automatic wait_rx_en(output int n);
        n = 0;
        while (!rx_en_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic request(input logic [5:0] p, input logic pe, input logic pt);
        cfg_prescale_i = p;
        cfg_par_en_i   = pe;
        cfg_par_typ_i  = pt;
        cfg_valid_i    = 1'b1;
        tick();
        cfg_valid_i    = 1'b0;
    endtask

    int  n;
    logic viol;

    initial begin
        rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_prescale_i = 6'd0;
        cfg_par_en_i = 1'b0; cfg_par_typ_i = 1'b0; rx_in_i = 1'b1;
        rx_busy_i = 1'b0; data_valid_i = 1'b0; err_stb_i = 1'b0; cnt_clr_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Reset state
        check_eq("rst_prescale", prescale_o, 8);
        check_eq("rst_par_en", par_en_o, 0);
        check_eq("rst_par_typ", par_typ_o, 0);
        check_eq("rst_rx_en", rx_en_o, 1);
        check_eq("rst_ready", cfg_ready_o, 1);
        check_eq("rst_cfg_err", cfg_err_o, 0);
        check_eq("rst_frame_cnt", frame_cnt_o, 0);
        check_eq("rst_err_cnt", err_cnt_o, 0);

        // Legal write 16/1/1 with idle line
        request(6'd16, 1'b1, 1'b1);
        check_eq("w16_ready_drop", cfg_ready_o, 0);
        check_eq("w16_rx_en_drain", rx_en_o, 1);
        tick();
        check_eq("w16_rx_en_off", rx_en_o, 0);
        check_eq("w16_presc_not_yet", prescale_o, 8);
        tick();
        check_eq("w16_prescale", prescale_o, 16);
        check_eq("w16_par_en", par_en_o, 1);
        check_eq("w16_par_typ", par_typ_o, 1);
        wait_rx_en(n);
        check_eq("w16_latency", 2 + n, 19);
        check_eq("w16_ready_back", cfg_ready_o, 1);

        // Write 32 while RX busy for 50 cycles
        rx_busy_i = 1'b1;
        request(6'd32, 1'b0, 1'b0);
        viol = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) data_valid_i = 1'b1;
            tick();
            data_valid_i = 1'b0;
            if (!rx_en_o || prescale_o != 6'd16 || cfg_ready_o) viol = 1'b1;
        end
        check_eq("busy_hold", viol, 0);
        check_eq("busy_dv_counted", frame_cnt_o, 1);
        rx_busy_i = 1'b0;
        tick();
        check_eq("busy_rx_en_off", rx_en_o, 0);
        tick();
        check_eq("busy_prescale", prescale_o, 32);
        check_eq("busy_par_en", par_en_o, 0);
        wait_rx_en(n);
        check_eq("busy_latency", 2 + n, 19);

        // Illegal prescale 12
        request(6'd12, 1'b1, 1'b0);
        check_eq("ill_cfg_err", cfg_err_o, 1);
        check_eq("ill_ready", cfg_ready_o, 1);
        tick();
        check_eq("ill_err_pulse_end", cfg_err_o, 0);
        check_eq("ill_prescale", prescale_o, 32);
        check_eq("ill_par_en", par_en_o, 0);
        check_eq("ill_ready2", cfg_ready_o, 1);

        // Counters
        cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
        check_eq("clr_frame", frame_cnt_o, 0);
        data_valid_i = 1'b1;
        repeat (300) tick();
        data_valid_i = 1'b0;
        check_eq("sat_frame", frame_cnt_o, 255);
        err_stb_i = 1'b1;
        repeat (3) tick();
        err_stb_i = 1'b0;
        check_eq("err_cnt3", err_cnt_o, 3);
        data_valid_i = 1'b1; err_stb_i = 1'b1; tick();
        check_eq("both_frame_sat", frame_cnt_o, 255);
        check_eq("both_err", err_cnt_o, 4);
        err_stb_i = 1'b0; cnt_clr_i = 1'b1; tick();
        check_eq("clr_prio_frame", frame_cnt_o, 0);
        check_eq("clr_prio_err", err_cnt_o, 0);
        cnt_clr_i = 1'b0; err_stb_i = 1'b1; tick();
        data_valid_i = 1'b0; err_stb_i = 1'b0;
        check_eq("both_inc_frame", frame_cnt_o, 1);
        check_eq("both_inc_err", err_cnt_o, 1);

        // Settle with a glitch on the 10th settle cycle
        request(6'd8, 1'b1, 1'b0);
        tick();
        tick();
        check_eq("gl_prescale", prescale_o, 8);
`ifdef UART_RX_CFG_CNT_CLR_ON_APPLY_EN
        check_eq("apply_frame_cnt", frame_cnt_o, 0);
        check_eq("apply_err_cnt", err_cnt_o, 0);
`else
        check_eq("apply_frame_cnt", frame_cnt_o, 1);
        check_eq("apply_err_cnt", err_cnt_o, 1);
`endif
        repeat (9) tick();
        rx_in_i = 1'b0;
        tick();
        check_eq("gl_rx_en_low", rx_en_o, 0);
        rx_in_i = 1'b1;
        wait_rx_en(n);
        check_eq("gl_restart", n, 17);

        // Reset mid-sequence after the new config was applied
        request(6'd16, 1'b1, 1'b1);
        tick();
        tick();
        check_eq("mid_applied", prescale_o, 16);
        rst_ni = 1'b0;
        #2;
        check_eq("mid_rst_prescale", prescale_o, 8);
        check_eq("mid_rst_rx_en", rx_en_o, 1);
        check_eq("mid_rst_ready", cfg_ready_o, 1);
        tick();
        rst_ni = 1'b1;
        repeat (5) tick();
        check_eq("mid_post_prescale", prescale_o, 8);
        check_eq("mid_post_par_en", par_en_o, 0);
        check_eq("mid_post_rx_en", rx_en_o, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg_ctrl.md
Name: uart_rx_cfg_ctrl

Overview:
Runtime configuration controller and frame scheduler for the UART receive path. It holds the live PRESCALE/PAR_EN/PAR_TYP settings that drive the RX FSM, edge/bit counter and parity checker. New settings are applied only at a frame boundary: the receiver is gated off, the config is updated, and the receiver is re-enabled only after the line is proven idle. It also keeps saturating good-frame and dropped-frame counters for status readback by the system controller.

Parameters:
SETTLE_CYC, 16, consecutive CLK cycles RX_IN must be high after an apply before RX_EN is re-asserted (legal range 1..255)
PRESCALE_RST, 8, PRESCALE value after reset (must be 8, 16 or 32)
CNT_W, 8, width of FRAME_CNT and ERR_CNT

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
CFG_VALID  in  1  config write request
CFG_READY  out  1  controller can accept a config write
CFG_PRESCALE  in  6  requested oversampling ratio
CFG_PAR_EN  in  1  requested parity enable
CFG_PAR_TYP  in  1  requested parity type (0 even, 1 odd)
CFG_ERR  out  1  one-cycle pulse: request rejected (illegal prescale)
RX_IN  in  1  serial line, already synchronised
RX_BUSY  in  1  high whenever the RX FSM is outside its idle state
DATA_VALID  in  1  one-cycle pulse: good frame received
ERR_STB  in  1  one-cycle pulse: frame dropped (parity/stop/start error)
CNT_CLR  in  1  synchronous clear of both counters
PRESCALE  out  6  live prescale to RX datapath
PAR_EN  out  1  live parity enable
PAR_TYP  out  1  live parity type
RX_EN  out  1  receiver enable; RX FSM must not leave idle while low
FRAME_CNT  out  CNT_W  saturating good-frame count
ERR_CNT  out  CNT_W  saturating dropped-frame count

Behaviour:
- Reset values: PRESCALE=PRESCALE_RST, PAR_EN=0, PAR_TYP=0, RX_EN=1, CFG_READY=1, CFG_ERR=0, FRAME_CNT=0, ERR_CNT=0, state RUN, settle counter 0.
- All outputs are registered. Handshake: the request is accepted on the cycle CFG_VALID&&CFG_READY. CFG_READY is high only in RUN.
- States: RUN, DRAIN, APPLY, SETTLE.
- RUN: accept request. If CFG_PRESCALE is not in {8,16,32}: CFG_ERR pulses the next cycle, the config is unchanged, and the state stays RUN. If legal: latch the request into shadow registers, drop CFG_READY, and go to DRAIN.
- DRAIN: RX_EN stays 1 while RX_BUSY=1, so the in-flight frame completes. On the first cycle with RX_BUSY=0, RX_EN goes to 0 next cycle and the state moves to APPLY.
- APPLY: exactly one cycle. Copy the shadow registers to PRESCALE/PAR_EN/PAR_TYP, clear the settle counter, and go to SETTLE.
- SETTLE: RX_EN=0. The counter increments each cycle RX_IN=1 and resets to 0 on any cycle RX_IN=0. When the count reaches SETTLE_CYC: RX_EN=1 and CFG_READY=1 next cycle, then return to RUN.
- Minimum latency from acceptance to RX_EN=1 with the line idle and RX_BUSY=0: 3+SETTLE_CYC cycles.
- PRESCALE/PAR_EN/PAR_TYP never change while RX_BUSY=1 or RX_EN=1.
- DATA_VALID arriving in DRAIN is counted normally.
- Counters: FRAME_CNT increments on DATA_VALID and ERR_CNT increments on ERR_STB. Both saturate at all-ones and never wrap. Both strobes in the same cycle increment both counters.
- CNT_CLR has priority over an increment in the same cycle (result 0).
- Reset mid-sequence (any state) aborts the pending config. Shadow values are discarded and reset values are restored.
- CFG_VALID while CFG_READY=0 is ignored. The requester must hold the request until it is accepted.

Optional Feature:
Macro UART_RX_CFG_CNT_CLR_ON_APPLY_EN.
- Defined: in the APPLY cycle, FRAME_CNT and ERR_CNT are cleared to 0, so status reflects only the new config. A strobe coincident with APPLY is lost (the clear wins).
- Undefined: counters are unaffected by config changes and clear only on reset or CNT_CLR.

Test Plan:
- Reset release, idle line -> PRESCALE=8, PAR_EN=0, RX_EN=1, CFG_READY=1, counters 0.
- Write prescale 16, PAR_EN=1, PAR_TYP=1 with RX_BUSY=0, RX_IN=1, SETTLE_CYC=16 -> RX_EN low for the settle window, outputs 16/1/1 one cycle after DRAIN exit, RX_EN=1 exactly 19 cycles after acceptance.
- Write prescale 32 while RX_BUSY=1 for 50 cycles -> PRESCALE stays 8 and RX_EN stays 1 until RX_BUSY falls, then the apply sequence runs.
- Write prescale 12 -> single-cycle CFG_ERR, PRESCALE stays 8, CFG_READY never drops.
- In SETTLE, drive RX_IN low on cycle 10 -> counter restarts; RX_EN rises only after 16 further consecutive high cycles.
- Pulse DATA_VALID 300 times with CNT_W=8 -> FRAME_CNT=255. DATA_VALID+ERR_STB together -> both counters increment. CNT_CLR with DATA_VALID -> FRAME_CNT=0. With the macro defined, an apply clears both counters.
